uart_mem_bridge: RTL
====================

Name: uart_mem_bridge

Overview:
Parametrised successor to the CPU-side UART memory link. Converts a CPU load/store request into a byte-framed serial transaction over a byte-level UART TX/RX handshake, supporting configurable address/data widths and byte strobes. Reads return little-endian data bytes. Writes require an ACK/NAK byte from the remote side. Sits between the CPU memory stage and the byte UART TX/RX cores.

Parameters:
ADDR_W, 32, address width in bits; multiple of 8, range 8..32.
DATA_W, 32, data width in bits; one of 8, 16, 32.
TIMEOUT_CYC, 100000, idle clock cycles allowed between expected RX bytes (used only with the optional feature).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
write_enable  in  1  store request; held high until mem_done
read_enable  in  1  load request; held high until mem_done
byte_en  in  DATA_W/8  write byte strobes
address  in  ADDR_W  request address
writeData  in  DATA_W  store data
readData  out  DATA_W  last successfully read data
mem_done  out  1  one-cycle completion pulse
mem_err  out  1  error flag, valid only while mem_done=1
tx_byte  out  8  byte to UART TX
tx_valid  out  1  tx_byte valid
tx_ready  in  1  UART TX accepts the byte when tx_valid&tx_ready
rx_byte  in  8  byte from UART RX
rx_valid  in  1  one-cycle strobe, rx_byte valid

Behaviour:
- Reset values: state IDLE; readData=0; mem_done=0; mem_err=0; tx_valid=0; tx_byte=0; armed=1; timeout counter=0. Reset is honoured mid-transaction, and any partial frame is abandoned.
- Frame sent for each request: a header byte, then ADDR_W/8 address bytes LSB-first, then (writes only) DATA_W/8 data bytes LSB-first.
  - Header = {wr, 3'b000, strb[3:0]}. strb = byte_en zero-extended to 4 bits for writes. strb = all DATA_W/8 bits set for reads.
- Request acceptance:
  - Accept only in IDLE with armed=1.
  - If both enables are high, write has priority.
  - address, writeData, byte_en and the request type are latched on acceptance. Later input changes are ignored.
  - Deasserting an enable mid-transaction does not abort the transaction.
- Re-arm: armed clears when the request is accepted. It sets again only after a cycle in which both enables are sampled low. This prevents a stale, still-held enable from re-issuing the request after mem_done.
- States:
  - IDLE -> HDR on accept.
  - HDR -> ADDR after header handshake.
  - ADDR: byte counter counts handshakes; after the last address byte -> WDATA (write) or RDATA (read).
  - WDATA: after the last data byte -> WAIT_ACK.
  - WAIT_ACK: rx 0x06 -> DONE with err=0. rx 0x15 or any other byte -> DONE with err=1.
  - RDATA: each rx_valid shifts a byte into the assembly register (LSB-first). After DATA_W/8 bytes -> DONE; readData updates on the DONE entry edge.
  - DONE: mem_done=1 for exactly one cycle, mem_err as determined, then -> IDLE.
- tx_valid/tx_byte are registered. They stay stable until the handshake completes, and at most one byte is transferred per cycle.
- rx_valid arriving in IDLE/HDR/ADDR/WDATA is discarded.
- readData holds its value on write transactions and on errored reads.

Optional Feature:
Macro UART_MEM_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_ACK and RDATA, clears on each rx_valid, and clears on entry to either state.
  - Reaching TIMEOUT_CYC -> DONE with mem_err=1; any partial read data is discarded.
- Undefined: no counter; WAIT_ACK/RDATA wait indefinitely; mem_err is set only by NAK or a bad ACK byte.

Test Plan:
1. Write, addr=0x00001004, data=0xDEADBEEF, byte_en=0xF, tx_ready=1 -> TX sequence 0x8F,0x04,0x10,0x00,0x00,0xEF,0xBE,0xAD,0xDE; rx 0x06 -> mem_done pulse, mem_err=0, readData unchanged.
2. Read, addr=0x00000020 -> TX 0x0F,0x20,0x00,0x00,0x00; rx 0x78,0x56,0x34,0x12 -> readData=0x12345678 on the mem_done cycle, mem_err=0.
3. Write with byte_en=0x3 and rx 0x15 -> header 0x83, mem_done with mem_err=1; hold write_enable high 5 cycles after done -> no new TX byte until the enable drops for 1 cycle.
4. Both enables high together -> write frame (header bit7=1); tx_ready toggling 1/0 every cycle -> each byte held stable until accepted, byte order unchanged.
5. Reset asserted after 2 address bytes of a read -> outputs return to reset values immediately (asynchronous); after release, a new read completes normally.
6. With UART_MEM_TIMEOUT_EN and TIMEOUT_CYC=50, a read receiving only 2 bytes -> mem_done, mem_err=1 exactly 50 cycles after the last rx byte, readData unchanged.

Source files
------------

// File: rtl/uart_mem_bridge_if.sv
// CPU load/store and byte-UART handshake bundle for uart_mem_bridge.
// slave = bridge view, master = CPU/UART-side view.
interface uart_mem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  write_enable;
  logic                  read_enable;
  logic [DATA_W/8-1:0]   byte_en;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     writeData;
  logic [DATA_W-1:0]     readData;
  logic                  mem_done;
  logic                  mem_err;
  logic [7:0]            tx_byte;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [7:0]            rx_byte;
  logic                  rx_valid;

  modport slave (
    input  write_enable, read_enable, byte_en, address, writeData,
    input  tx_ready, rx_byte, rx_valid,
    output readData, mem_done, mem_err, tx_byte, tx_valid
  );

  modport master (
    output write_enable, read_enable, byte_en, address, writeData,
    output tx_ready, rx_byte, rx_valid,
    input  readData, mem_done, mem_err, tx_byte, tx_valid
  );
endinterface

// File: rtl/uart_mem_bridge.sv
// Bridges CPU load/store requests to a byte-framed UART link (header, address LSB-first, write data LSB-first).
// Optional RX inactivity timeout in WAIT_ACK/RDATA enabled by defining UART_MEM_TIMEOUT_EN.
//   state    | meaning
//   IDLE     | waiting for an armed request      HDR   | sending header byte
//   ADDR     | sending address bytes             WDATA | sending write data bytes
//   WAIT_ACK | waiting for ACK/NAK byte          RDATA | collecting read data bytes
//   DONE     | one-cycle completion pulse
module uart_mem_bridge #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  uart_mem_bridge_if.slave  bus
);

  localparam int         NA        = ADDR_W / 8;
  localparam int         NB        = DATA_W / 8;
  localparam logic [2:0] ADDR_LAST = 3'(NA - 1);
  localparam logic [2:0] DATA_LAST = 3'(NB - 1);
  localparam logic [3:0] RD_STRB   = 4'((1 << NB) - 1);
  localparam logic [7:0] ACK_BYTE  = 8'h06;

  if ((ADDR_W % 8) != 0 || ADDR_W < 8 || ADDR_W > 32) begin : g_bad_addr_w
    $error("uart_mem_bridge: ADDR_W must be a multiple of 8 in 8..32");
  end
  if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32) begin : g_bad_data_w
    $error("uart_mem_bridge: DATA_W must be 8, 16 or 32");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("uart_mem_bridge: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_ADDR,
    S_WDATA,
    S_WAIT_ACK,
    S_RDATA,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_armed;
  logic                r_wr;
  logic                r_err;
  logic                r_tx_valid;
  logic [7:0]          r_tx_byte;
  logic [2:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr_sh;
  logic [DATA_W-1:0]   r_data_sh;
  logic [DATA_W-1:0]   r_asm;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_accept;
  logic                w_tx_hs;
  logic                w_rx_last;
  logic                w_timeout;
  logic [DATA_W-1:0]   w_asm_nxt;

  assign w_accept  = (r_state == S_IDLE) && r_armed && (bus.write_enable || bus.read_enable);
  assign w_tx_hs   = r_tx_valid && bus.tx_ready;
  assign w_rx_last = bus.rx_valid && (r_cnt == DATA_LAST);
  // Bytes arrive LSB-first, so each new byte enters at the top and shifts down.
  assign w_asm_nxt = (r_asm >> 8) | (DATA_W'(bus.rx_byte) << (DATA_W - 8));

`ifdef UART_MEM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_waiting;

  assign w_waiting = (r_state == S_WAIT_ACK) || (r_state == S_RDATA);
  assign w_timeout = w_waiting && !bus.rx_valid && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (w_waiting && !bus.rx_valid && !w_timeout) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_state_nxt = S_HDR;
      S_HDR:      if (w_tx_hs) w_state_nxt = S_ADDR;
      S_ADDR:     if (w_tx_hs && (r_cnt == ADDR_LAST)) w_state_nxt = r_wr ? S_WDATA : S_RDATA;
      S_WDATA:    if (w_tx_hs && (r_cnt == DATA_LAST)) w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (bus.rx_valid || w_timeout) w_state_nxt = S_DONE;
      S_RDATA:    if (w_rx_last || w_timeout) w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed    <= 1'b1;
      r_wr       <= 1'b0;
      r_err      <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_byte  <= '0;
      r_cnt      <= '0;
      r_addr_sh  <= '0;
      r_data_sh  <= '0;
      r_asm      <= '0;
      r_rdata    <= '0;
    end else begin
      // Re-arm only after both enables were seen low, so a held enable cannot replay.
      if (w_accept) begin
        r_armed <= 1'b0;
      end else if (!bus.write_enable && !bus.read_enable) begin
        r_armed <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wr       <= bus.write_enable;
            r_addr_sh  <= bus.address;
            r_data_sh  <= bus.writeData;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_tx_valid <= 1'b1;
            r_tx_byte  <= {bus.write_enable, 3'b000,
                           bus.write_enable ? 4'(bus.byte_en) : RD_STRB};
          end
        end
        S_HDR: begin
          if (w_tx_hs) begin
            r_tx_byte <= r_addr_sh[7:0];
            r_addr_sh <= r_addr_sh >> 8;
            r_cnt     <= '0;
          end
        end
        S_ADDR: begin
          if (w_tx_hs) begin
            if (r_cnt == ADDR_LAST) begin
              r_cnt <= '0;
              r_asm <= '0;
              if (r_wr) begin
                r_tx_byte <= r_data_sh[7:0];
                r_data_sh <= r_data_sh >> 8;
              end else begin
                r_tx_valid <= 1'b0;
              end
            end else begin
              r_cnt     <= r_cnt + 3'd1;
              r_tx_byte <= r_addr_sh[7:0];
              r_addr_sh <= r_addr_sh >> 8;
            end
          end
        end
        S_WDATA: begin
          if (w_tx_hs) begin
            if (r_cnt == DATA_LAST) begin
              r_tx_valid <= 1'b0;
            end else begin
              r_cnt     <= r_cnt + 3'd1;
              r_tx_byte <= r_data_sh[7:0];
              r_data_sh <= r_data_sh >> 8;
            end
          end
        end
        S_WAIT_ACK: begin
          if (bus.rx_valid) begin
            r_err <= (bus.rx_byte != ACK_BYTE);
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        S_RDATA: begin
          if (bus.rx_valid) begin
            r_asm <= w_asm_nxt;
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == DATA_LAST) begin
              r_rdata <= w_asm_nxt;
            end
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.readData = r_rdata;
  assign bus.mem_done = (r_state == S_DONE);
  assign bus.mem_err  = (r_state == S_DONE) && r_err;
  assign bus.tx_byte  = r_tx_byte;
  assign bus.tx_valid = r_tx_valid;

endmodule
